// File: rtl/hms_alarm.sv
// Alarm stage fed by the hrs/min/sec timekeeper: programmable alarm time,
// ring with seconds timeout, and a bounded number of snoozes per event.
module hms_alarm #(
    parameter int RING_SEC   = 30,
    parameter int SNOOZE_SEC = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hrs,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [5:0] din,
    input  logic [1:0] addr,
    input  logic       load,
    input  logic       al_en,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       snoozing,
    output logic [4:0] al_hrs,
    output logic [5:0] al_min,
    output logic [1:0] snooze_cnt
);

    localparam logic [15:0] RING_LD   = 16'(RING_SEC);
    localparam logic [15:0] SNOOZE_LD = 16'(SNOOZE_SEC);
    localparam logic [1:0]  MAX_SNZ   = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RING,
        ST_SNOOZE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  sec_q;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  snz_q, snz_d;
    logic [4:0]  al_hrs_q, al_hrs_d;
    logic [5:0]  al_min_q, al_min_d;
    logic        tick, hit, expire;

    // Any change of the seconds value counts as a tick, so edits and wraps both tick.
    assign tick   = (sec != sec_q);
    assign hit    = al_en && tick && (sec == 6'd0) && (hrs == al_hrs_q) && (min == al_min_q);
    assign expire = tick && (cnt_q == 16'd1);

    always_comb begin
        al_min_d = al_min_q;
        al_hrs_d = al_hrs_q;
        if (load && (addr == 2'd2) && (din <= 6'd59)) al_min_d = din;
        if (load && (addr == 2'd3) && (din <= 6'd23)) al_hrs_d = din[4:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snz_d   = snz_q;
        if (state_q != ST_IDLE && tick) cnt_d = cnt_q - 16'd1;
        unique case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_RING;
                    cnt_d   = RING_LD;
                    snz_d   = 2'd0;
                end
            end
            ST_RING: begin
                if (!al_en || stop) begin
                    state_d = ST_IDLE;
                end else if (snooze && (snz_q < MAX_SNZ)) begin
                    state_d = ST_SNOOZE;
                    cnt_d   = SNOOZE_LD;
                    snz_d   = snz_q + 2'd1;
                end else if (expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNOOZE: begin
                if (!al_en || stop) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = ST_RING;
                    cnt_d   = RING_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sec_q    <= 6'd0;
            cnt_q    <= 16'd0;
            snz_q    <= 2'd0;
            al_hrs_q <= 5'd0;
            al_min_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            sec_q    <= sec;
            cnt_q    <= cnt_d;
            snz_q    <= snz_d;
            al_hrs_q <= al_hrs_d;
            al_min_q <= al_min_d;
        end
    end

    assign ring       = (state_q == ST_RING);
    assign snoozing   = (state_q == ST_SNOOZE);
    assign al_hrs     = al_hrs_q;
    assign al_min     = al_min_q;
    assign snooze_cnt = snz_q;

endmodule

// File: tb/tb_hms_alarm.sv
// Directed + randomized bench for hms_alarm against a tick-count based reference model.
module tb_hms_alarm;

    localparam int RING_SEC   = 30;
    localparam int SNOOZE_SEC = 300;
    localparam int MAX_SNOOZE = 3;
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hrs = '0;
    logic [5:0] min = '0;
    logic [5:0] sec = '0;
    logic [5:0] din = '0;
    logic [1:0] addr = '0;
    logic       load = 1'b0;
    logic       al_en = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       ring, snoozing;
    logic [4:0] al_hrs;
    logic [5:0] al_min;
    logic [1:0] snooze_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: absolute tick counter and a deadline per ring/snooze period
    int m_prev_sec, m_al_h, m_al_m, m_mode, m_snz, m_ticks, m_deadline;
    int tod;

    hms_alarm #(.RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC), .MAX_SNOOZE(MAX_SNOOZE)) dut (
        .clk(clk), .rst(rst), .hrs(hrs), .min(min), .sec(sec), .din(din), .addr(addr),
        .load(load), .al_en(al_en), .snooze(snooze), .stop(stop), .ring(ring),
        .snoozing(snoozing), .al_hrs(al_hrs), .al_min(al_min), .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_sec = 0; m_al_h = 0; m_al_m = 0; m_mode = M_IDLE;
        m_snz = 0; m_ticks = 0; m_deadline = 0;
    endtask

    task automatic model_edge();
        bit t, h;
        t = (int'(sec) != m_prev_sec);
        m_prev_sec = int'(sec);
        if (t) m_ticks++;
        h = al_en && t && (sec == 0) && (int'(hrs) == m_al_h) && (int'(min) == m_al_m);
        if (m_mode == M_IDLE) begin
            if (h) begin
                m_mode = M_RING; m_deadline = m_ticks + RING_SEC; m_snz = 0;
            end
        end else if (!al_en || stop) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_RING) begin
            if (snooze && m_snz < MAX_SNOOZE) begin
                m_mode = M_SNOOZE; m_deadline = m_ticks + SNOOZE_SEC; m_snz++;
            end else if (t && m_ticks == m_deadline) begin
                m_mode = M_IDLE;
            end
        end else begin
            if (t && m_ticks == m_deadline) begin
                m_mode = M_RING; m_deadline = m_ticks + RING_SEC;
            end
        end
        if (load && addr == 2 && din <= 59) m_al_m = int'(din);
        if (load && addr == 3 && din <= 23) m_al_h = int'(din);
    endtask

    task automatic chk_all();
        chk("ring", 16'(ring), 16'(m_mode == M_RING));
        chk("snoozing", 16'(snoozing), 16'(m_mode == M_SNOOZE));
        chk("al_hrs", 16'(al_hrs), 16'(m_al_h));
        chk("al_min", 16'(al_min), 16'(m_al_m));
        chk("snooze_cnt", 16'(snooze_cnt), 16'(m_snz));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
    endtask

    task automatic set_time(input int t);
        tod = ((t % 86400) + 86400) % 86400;
        hrs = 5'(tod / 3600);
        min = 6'((tod / 60) % 60);
        sec = 6'(tod % 60);
    endtask

    task automatic hold_time(input int t, input int holds);
        set_time(t);
        repeat (holds) step();
    endtask

    task automatic do_load(input int a, input int d);
        addr = 2'(a); din = 6'(d); load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1; step(); snooze = 1'b0;
    endtask

    // Bring on a fresh alarm event at 07:30:00
    task automatic start_event();
        hold_time(7*3600 + 29*60 + 59, 2);
        hold_time(7*3600 + 30*60, 2);
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk_all();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // loads, including out-of-range and ignored addresses
        do_load(3, 7);
        do_load(2, 30);
        chk("al_hrs_load", 16'(al_hrs), 16'd7);
        chk("al_min_load", 16'(al_min), 16'd30);
        do_load(2, 60);
        do_load(3, 24);
        do_load(1, 5);
        chk("al_min_oor", 16'(al_min), 16'd30);
        chk("al_hrs_oor", 16'(al_hrs), 16'd7);
        al_en = 1'b1;

        // hit and natural timeout
        hold_time(7*3600 + 29*60 + 59, 5);
        chk("no_ring_early", 16'(ring), 16'd0);
        set_time(7*3600 + 30*60);
        step();
        chk("ring_rise", 16'(ring), 16'd1);
        repeat (4) step();
        for (int s = 1; s < 30; s++) hold_time(7*3600 + 30*60 + s, 3);
        chk("ring_at_29", 16'(ring), 16'd1);
        set_time(7*3600 + 30*60 + 30);
        step();
        chk("ring_timeout", 16'(ring), 16'd0);
        chk("cnt_after_timeout", 16'(snooze_cnt), 16'd0);
        repeat (2) step();

        // snooze up to the limit, then an ignored 4th snooze
        start_event();
        for (int k = 1; k <= MAX_SNOOZE; k++) begin
            pulse_snooze();
            chk("snooze_enter", 16'(snoozing), 16'd1);
            chk("snooze_cnt_inc", 16'(snooze_cnt), 16'(k));
            for (int s = 1; s <= SNOOZE_SEC; s++) hold_time(tod + 1, 1);
            chk("ring_after_snooze", 16'(ring), 16'd1);
        end
        pulse_snooze();
        chk("snooze_ignored", 16'(ring), 16'd1);
        chk("snooze_cnt_sat", 16'(snooze_cnt), 16'd3);
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_idle", 16'(ring), 16'd0);

        // stop wins over simultaneous snooze; count unchanged
        start_event();
        pulse_snooze();
        for (int s = 1; s <= SNOOZE_SEC; s++) hold_time(tod + 1, 1);
        stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
        chk("stop_wins_ring", 16'(ring), 16'd0);
        chk("stop_wins_snz", 16'(snoozing), 16'd0);
        chk("stop_wins_cnt", 16'(snooze_cnt), 16'd1);

        // al_en drop during snooze
        start_event();
        pulse_snooze();
        hold_time(tod + 1, 2);
        al_en = 1'b0; step(); al_en = 1'b1;
        chk("en_drop_snz", 16'(snoozing), 16'd0);
        step();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            int r, holds;
            r = int'($urandom_range(0, 99));
            if (r < 8)       set_time(m_al_h*3600 + m_al_m*60 - 1 - int'($urandom_range(0, 2)));
            else if (r < 12) set_time(int'($urandom_range(0, 86399)));
            else             set_time(tod + 1);
            snooze = ($urandom_range(0, 99) < 15);
            stop   = ($urandom_range(0, 99) < 4);
            al_en  = ($urandom_range(0, 49) != 0);
            load   = ($urandom_range(0, 99) < 5);
            addr   = 2'($urandom_range(0, 3));
            din    = 6'($urandom_range(0, 63));
            step();
            snooze = 1'b0; stop = 1'b0; load = 1'b0; al_en = 1'b1;
            holds = int'($urandom_range(0, 2));
            repeat (holds) step();
        end

        // async reset mid-ring
        do_load(3, 7);
        do_load(2, 30);
        start_event();
        chk("ring_before_rst", 16'(ring), 16'd1);
        #3 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_ring", 16'(ring), 16'd0);
        chk("rst_al_hrs", 16'(al_hrs), 16'd0);
        chk("rst_al_min", 16'(al_min), 16'd0);
        chk_all();
        set_time(0);
        #2 rst = 1'b1;
        repeat (4) step();
        chk("no_ring_after_rst", 16'(ring), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
